// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word-organised memory with byte/halfword/word
// lanes, a fixed number of wait states and a two-cycle ERROR response.
module ahb_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [31:0] Haddr,
  input  logic [2:0]  Hsize,
  input  logic [31:0] Hwdata,
  input  logic        Hreadyin,
  output logic [31:0] Hrdata,
  output logic [1:0]  Hresp,
  output logic        Hreadyout
);

  localparam int          IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] SPAN  = 33'(MEM_DEPTH) << 2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         lane_q, lane_d;
  logic [2:0]         size_q, size_d;
  logic               write_q, write_d;
  logic               hready_q, hready_d;
  logic [1:0]         resp_q, resp_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [31:0]        mem [MEM_DEPTH];

  logic [32:0]        offset;
  logic               in_range, misaligned, illegal, accept, commit;
  logic [IDX_W-1:0]   rd_idx;
  logic [3:0]         be;
  logic [31:0]        merged;
  logic               unused_htrans0;

  assign unused_htrans0 = Htrans[0];

  assign offset     = {1'b0, Haddr} - {1'b0, BASE_ADDR};
  assign in_range   = (Haddr >= BASE_ADDR) && (offset < SPAN);
  assign misaligned = ((Hsize == 3'b001) && Haddr[0]) ||
                      ((Hsize == 3'b010) && (Haddr[1:0] != 2'b00));
  assign illegal    = !in_range || (Hsize > 3'b010) || misaligned;
  assign accept     = Hreadyin && Htrans[1];

  // The pending write is committed at the edge that ends LAST.
  assign commit = (state_q == S_LAST) && write_q;

  always_comb begin
    be = 4'b0000;
    case (size_q)
      3'b000:  be = 4'b0001 << lane_q;
      3'b001:  be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // From WAIT the read uses the captured index; otherwise it is a fresh address phase.
  assign rd_idx = (state_q == S_WAIT) ? idx_q : offset[IDX_W+1:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fwd
      assign merged[8*gi +: 8] = (commit && be[gi] && (rd_idx == idx_q)) ?
                                 Hwdata[8*gi +: 8] : mem[rd_idx][8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
    rdata_d = '0;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_LAST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = offset[IDX_W+1:2];
          lane_d  = Haddr[1:0];
          size_d  = Hsize;
          write_d = Hwrite;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = S_LAST;
          end
        end
      end
    endcase
    if ((state_d == S_LAST) && !write_d) rdata_d = merged;
    hready_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    resp_d   = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      resp_q   <= 2'b00;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lane_q   <= lane_d;
      size_q   <= size_d;
      write_q  <= write_d;
      hready_q <= hready_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
    end
  end

  // Memory contents survive reset, but a write ending on a reset edge is dropped.
  always_ff @(posedge Hclk) begin
    if (Hresetn && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= Hwdata[8*i +: 8];
      end
    end
  end

  assign Hrdata    = rdata_q;
  assign Hresp     = resp_q;
  assign Hreadyout = hready_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a three-wait instance driven by a
// pipelined AHB master loop, with expectations queued at address acceptance.
module tb_ahb_slave_mem;

  logic        clk = 1'b0;
  logic        hresetn;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        sel;

  logic [1:0]  htrans0, htrans1;
  logic [31:0] rd0, rd1, rdata_m;
  logic [1:0]  rs0, rs1, resp_m;
  logic        ho0, ho1, hready_m;

  always #5 clk = ~clk;

  assign htrans0  = sel ? 2'b00 : htrans;
  assign htrans1  = sel ? htrans : 2'b00;
  assign rdata_m  = sel ? rd1 : rd0;
  assign resp_m   = sel ? rs1 : rs0;
  assign hready_m = sel ? ho1 : ho0;

  ahb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .Hclk(clk), .Hresetn(hresetn), .Htrans(htrans0), .Hwrite(hwrite),
    .Haddr(haddr), .Hsize(hsize), .Hwdata(hwdata), .Hreadyin(ho0),
    .Hrdata(rd0), .Hresp(rs0), .Hreadyout(ho0)
  );

  ahb_slave_mem #(.WAIT_STATES(3)) dut3 (
    .Hclk(clk), .Hresetn(hresetn), .Htrans(htrans1), .Hwrite(hwrite),
    .Haddr(haddr), .Hsize(hsize), .Hwdata(hwdata), .Hreadyin(ho1),
    .Hrdata(rd1), .Hresp(rs1), .Hreadyout(ho1)
  );

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_waits;
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int add(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                             input logic [2:0] sz, input logic [31:0] wd, input logic [1:0] rsp,
                             input logic [31:0] rdv, input int w);
    vec_t v;
    v.trans = tr; v.wr = wr; v.addr = a; v.size = sz; v.wdata = wd;
    v.exp_resp = rsp; v.exp_rdata = rdv; v.exp_waits = w;
    tbl.push_back(v);
    return tbl.size() - 1;
  endfunction

  task automatic drive_addr(input int idx);
    if (idx < 0) begin
      htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'b000;
    end else begin
      htrans = tbl[idx].trans; hwrite = tbl[idx].wr;
      haddr  = tbl[idx].addr;  hsize  = tbl[idx].size;
    end
  endtask

  // Called just after a rising edge with the bus idle; returns in the same phase.
  task automatic run_seq(input int first, input int last, input logic s);
    int   a_idx = first;
    int   waits = 0;
    int   budget = 0;
    bit   have_d = 0;
    bit   adv;
    exp_t cur, e;
    sel = s;
    drive_addr(a_idx);
    while ((a_idx <= last || have_d) && budget < 500) begin
      @(negedge clk);
      budget++;
      adv = hready_m;
      if (have_d) begin
        cur = sb[0];
        if (!hready_m) begin
          waits++;
          chk($sformatf("v%0d_wait_resp", cur.idx), 32'(resp_m), 32'(cur.resp));
          chk($sformatf("v%0d_wait_rdata", cur.idx), rdata_m, 32'h0);
        end else begin
          cur = sb.pop_front();
          chk($sformatf("v%0d_resp", cur.idx), 32'(resp_m), 32'(cur.resp));
          chk($sformatf("v%0d_rdata", cur.idx), rdata_m, cur.rdata);
          chk($sformatf("v%0d_waits", cur.idx), 32'(waits), 32'(cur.waits));
          $display("xfer v%0d: trans=%b wr=%b addr=%h size=%0d resp=%b rdata=%h waits=%0d",
                   cur.idx, tbl[cur.idx].trans, tbl[cur.idx].wr, tbl[cur.idx].addr,
                   tbl[cur.idx].size, resp_m, rdata_m, waits);
        end
      end
      @(posedge clk);
      #1;
      if (adv) begin
        have_d = 0;
        waits  = 0;
        if (a_idx <= last) begin
          e.idx = a_idx; e.resp = tbl[a_idx].exp_resp;
          e.rdata = tbl[a_idx].exp_rdata; e.waits = tbl[a_idx].exp_waits;
          sb.push_back(e);
          hwdata = tbl[a_idx].wdata;
          have_d = 1;
          a_idx++;
          drive_addr((a_idx <= last) ? a_idx : -1);
        end
      end
    end
    if (budget >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_seq_timeout: got %0d cycles expected completion", budget);
      sb.delete();
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    chk({name, "_ready"}, 32'(hready_m), 32'h1);
    chk({name, "_resp"}, 32'(resp_m), 32'h0);
    chk({name, "_rdata"}, rdata_m, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic write_ws3(input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1;
    htrans = 2'b10; hwrite = 1'b1; haddr = a; hsize = 3'b010;
    @(posedge clk);
    #1;
    htrans = 2'b00; hwrite = 1'b0; hwdata = d;
  endtask

  int w0_s, w0_e, w3a_s, w3a_e, w3b_s, w3b_e, w3c;

  initial begin
    w0_s = add(2'b10, 1, 32'h8000_0010, 3'd2, 32'hDEAD_BEEF, 2'b00, 32'h0, 0);
    void'(add(2'b10, 0, 32'h8000_0010, 3'd2, 32'h0,         2'b00, 32'hDEAD_BEEF, 0));
    void'(add(2'b10, 1, 32'h8000_0013, 3'd0, 32'hA577_6655, 2'b00, 32'h0, 0));
    void'(add(2'b10, 0, 32'h8000_0010, 3'd2, 32'h0,         2'b00, 32'hA5AD_BEEF, 0));
    void'(add(2'b10, 1, 32'h8000_0010, 3'd1, 32'h9999_1234, 2'b00, 32'h0, 0));
    void'(add(2'b11, 0, 32'h8000_0010, 3'd2, 32'h0,         2'b00, 32'hA5AD_1234, 0));
    void'(add(2'b00, 0, 32'h8000_0010, 3'd2, 32'h0,         2'b00, 32'h0, 0));
    void'(add(2'b01, 0, 32'h8000_0010, 3'd2, 32'h0,         2'b00, 32'h0, 0));
    void'(add(2'b10, 0, 32'h9000_0000, 3'd2, 32'h0,         2'b01, 32'h0, 1));
    void'(add(2'b10, 1, 32'h8000_0011, 3'd2, 32'hFFFF_FFFF, 2'b01, 32'h0, 1));
    void'(add(2'b10, 0, 32'h8000_0010, 3'd2, 32'h0,         2'b00, 32'hA5AD_1234, 0));
    void'(add(2'b10, 0, 32'h8000_0010, 3'd3, 32'h0,         2'b01, 32'h0, 1));
    void'(add(2'b10, 1, 32'h8000_0011, 3'd1, 32'hFFFF_FFFF, 2'b01, 32'h0, 1));
    void'(add(2'b10, 1, 32'h8000_03FC, 3'd2, 32'h0BAD_CAFE, 2'b00, 32'h0, 0));
    void'(add(2'b10, 0, 32'h8000_03FC, 3'd2, 32'h0,         2'b00, 32'h0BAD_CAFE, 0));
    void'(add(2'b10, 0, 32'h8000_0400, 3'd2, 32'h0,         2'b01, 32'h0, 1));
    void'(add(2'b10, 0, 32'h7FFF_FFFC, 3'd2, 32'h0,         2'b01, 32'h0, 1));
    void'(add(2'b10, 1, 32'h8000_03FE, 3'd1, 32'h5A5A_0000, 2'b00, 32'h0, 0));
    void'(add(2'b10, 0, 32'h8000_03FC, 3'd2, 32'h0,         2'b00, 32'h5A5A_CAFE, 0));
    w0_e = add(2'b10, 0, 32'h8000_0011, 3'd0, 32'h0,        2'b00, 32'hA5AD_1234, 0);
    w3a_s = add(2'b10, 1, 32'h8000_0010, 3'd2, 32'hCAFE_F00D, 2'b00, 32'h0, 3);
    void'(add(2'b10, 0, 32'h8000_0010, 3'd2, 32'h0,          2'b00, 32'hCAFE_F00D, 3));
    w3a_e = add(2'b10, 0, 32'h9000_0000, 3'd2, 32'h0,        2'b01, 32'h0, 1);
    w3b_s = add(2'b10, 1, 32'h8000_0020, 3'd2, 32'h0,        2'b00, 32'h0, 3);
    w3b_e = add(2'b10, 0, 32'h8000_0020, 3'd2, 32'h0,        2'b00, 32'h0, 3);
    w3c   = add(2'b10, 0, 32'h8000_0020, 3'd2, 32'h0,        2'b00, 32'h0, 3);

    // Reset held for three edges under random bus activity.
    hresetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      htrans = 2'($urandom_range(0, 3)); hwrite = 1'($urandom);
      haddr = $urandom; hsize = 3'($urandom_range(0, 7)); hwdata = $urandom;
      sel = 1'($urandom);
      @(posedge clk);
      #1;
      chk($sformatf("rst%0d_ready0", i), 32'(ho0), 32'h1);
      chk($sformatf("rst%0d_resp0", i), 32'(rs0), 32'h0);
      chk($sformatf("rst%0d_rdata0", i), rd0, 32'h0);
      chk($sformatf("rst%0d_ready3", i), 32'(ho1), 32'h1);
      chk($sformatf("rst%0d_resp3", i), 32'(rs1), 32'h0);
      chk($sformatf("rst%0d_rdata3", i), rd1, 32'h0);
    end
    hresetn = 1'b1;
    drive_addr(-1);
    hwdata = 32'h0;

    run_seq(w0_s, w0_e, 1'b0);
    check_idle("ws0_idle");
    run_seq(w3a_s, w3a_e, 1'b1);
    check_idle("ws3_idle");

    // Reset lands on the edge ending the second wait cycle.
    write_ws3(32'h8000_0020, 32'h1111_1111);
    @(negedge clk);
    chk("rstw_wait1", 32'(hready_m), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstw_wait2", 32'(hready_m), 32'h0);
    hresetn = 1'b0;
    @(posedge clk);
    #1;
    hresetn = 1'b1;
    check_idle("rstw_after");

    run_seq(w3b_s, w3b_e, 1'b1);

    // Reset lands on the edge ending LAST: the write must be dropped.
    write_ws3(32'h8000_0020, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstl_wait%0d", i), 32'(hready_m), 32'h0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rstl_last_ready", 32'(hready_m), 32'h1);
    chk("rstl_last_resp", 32'(resp_m), 32'h0);
    hresetn = 1'b0;
    @(posedge clk);
    #1;
    hresetn = 1'b1;
    check_idle("rstl_after");

    run_seq(w3c, w3c, 1'b1);
    check_idle("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
